// File: rtl/access_mon_pkg.sv
// Shared types and helpers for the multi-channel access monitor
// (access_monitor_mc and its per-channel slice access_mon_channel).
package access_mon_pkg;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // A zero threshold would never trip, so it is treated as "trip on the first failure".
  function automatic int unsigned norm_threshold(input int unsigned fail_max);
    return (fail_max == 0) ? 1 : fail_max;
  endfunction

endpackage

// File: rtl/access_mon_channel.sv
// One monitor channel: OPEN/LOCKED FSM, saturating consecutive-fail counter,
// sticky W1C alarm bit and, with ACCESS_MON_LOCKOUT_EN defined, a lockout timer.
module access_mon_channel
  import access_mon_pkg::*;
#(
  parameter int CNT_W = 4
`ifdef ACCESS_MON_LOCKOUT_EN
  ,
  parameter int LOCK_CYCLES = 16,
  parameter int LOCK_W      = $clog2(LOCK_CYCLES + 1)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             attempt_valid,
  input  logic             attempt_match,
  input  logic [CNT_W-1:0] cfg_fail_max,
  input  logic             irq_clr,
  output logic             access_granted,
  output logic             access_denied,
  output logic             locked,
  output logic [CNT_W-1:0] fail_count,
  output logic             irq_status
);

  logic             granted_q, granted_d;
  logic             denied_q, denied_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr;
  logic [CNT_W:0]   cnt_inc;
  logic             trip;
  logic             is_open;

  assign thr     = CNT_W'(norm_threshold(32'(cfg_fail_max)));
  // One extra bit so the trip compare sees the unsaturated count.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign trip    = cnt_inc >= {1'b0, thr};

`ifdef ACCESS_MON_LOCKOUT_EN
  state_e            state_q, state_d;
  logic [LOCK_W-1:0] timer_q, timer_d;

  assign is_open = (state_q == ST_OPEN);
`else
  assign is_open = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    granted_d = 1'b0;
    denied_d  = 1'b0;
    cnt_d     = cnt_q;
    irq_d     = irq_q & ~irq_clr;
`ifdef ACCESS_MON_LOCKOUT_EN
    state_d   = state_q;
    timer_d   = timer_q;
    if (state_q == ST_LOCKED) begin
      if (timer_q == '0) begin
        state_d = ST_OPEN;
      end else begin
        timer_d = timer_q - LOCK_W'(1);
      end
    end
`endif
    if (attempt_valid) begin
      if (!is_open) begin
        denied_d = 1'b1;
      end else if (attempt_match) begin
        granted_d = 1'b1;
        cnt_d     = '0;
      end else begin
        denied_d = 1'b1;
        cnt_d    = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
        // Set is applied after the clear above, so a coincident clear loses.
        if (trip) begin
          irq_d = 1'b1;
`ifdef ACCESS_MON_LOCKOUT_EN
          state_d = ST_LOCKED;
          timer_d = LOCK_W'(LOCK_CYCLES - 1);
          cnt_d   = '0;
`endif
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
`ifdef ACCESS_MON_LOCKOUT_EN
      state_q   <= ST_OPEN;
      timer_q   <= '0;
`endif
    end else begin
      granted_q <= granted_d;
      denied_q  <= denied_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
`ifdef ACCESS_MON_LOCKOUT_EN
      state_q   <= state_d;
      timer_q   <= timer_d;
`endif
    end
  end

  assign access_granted = granted_q;
  assign access_denied  = denied_q;
  assign fail_count     = cnt_q;
  assign irq_status     = irq_q;
`ifdef ACCESS_MON_LOCKOUT_EN
  assign locked         = (state_q == ST_LOCKED);
`else
  assign locked         = 1'b0;
`endif

endmodule

// File: rtl/access_monitor_mc.sv
// Multi-channel access monitor top: N_CH independent access_mon_channel slices,
// packed fail counts and a single IRQ. Timed lockout enabled by ACCESS_MON_LOCKOUT_EN.
module access_monitor_mc
  import access_mon_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 4,
  parameter int LOCK_CYCLES = 16,
  parameter int LOCK_W      = $clog2(LOCK_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       attempt_valid,
  input  logic [N_CH-1:0]       attempt_match,
  input  logic [CNT_W-1:0]      cfg_fail_max,
  input  logic [N_CH-1:0]       irq_clr,
  output logic [N_CH-1:0]       access_granted,
  output logic [N_CH-1:0]       access_denied,
  output logic [N_CH-1:0]       locked,
  output logic [N_CH*CNT_W-1:0] fail_count,
  output logic [N_CH-1:0]       irq_status,
  output logic                  irq
);

  if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
    $error("access_monitor_mc: LOCK_CYCLES must be >= 1");
  end
  if (LOCK_W != $clog2(LOCK_CYCLES + 1)) begin : g_bad_lock_w
    $error("access_monitor_mc: LOCK_W is derived and must not be overridden");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    access_mon_channel #(
      .CNT_W       (CNT_W)
`ifdef ACCESS_MON_LOCKOUT_EN
      ,
      .LOCK_CYCLES (LOCK_CYCLES),
      .LOCK_W      (LOCK_W)
`endif
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .attempt_valid  (attempt_valid[i]),
      .attempt_match  (attempt_match[i]),
      .cfg_fail_max   (cfg_fail_max),
      .irq_clr        (irq_clr[i]),
      .access_granted (access_granted[i]),
      .access_denied  (access_denied[i]),
      .locked         (locked[i]),
      .fail_count     (fail_count[i*CNT_W +: CNT_W]),
      .irq_status     (irq_status[i])
    );
  end

  // OR of registered bits only, so the CPU line cannot glitch.
  assign irq = |irq_status;

endmodule

// File: tb/tb_access_monitor_mc.sv
// Scoreboard bench for access_monitor_mc: a behavioural per-channel model pushes the
// expected post-edge outputs each cycle; they are popped and compared after the edge.
module tb_access_monitor_mc;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;
`ifdef ACCESS_MON_LOCKOUT_EN
  localparam int LOCK_CYCLES = 16;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N_CH-1:0]       attempt_valid = '0;
  logic [N_CH-1:0]       attempt_match = '0;
  logic [CNT_W-1:0]      cfg_fail_max = 4'd3;
  logic [N_CH-1:0]       irq_clr = '0;
  logic [N_CH-1:0]       access_granted;
  logic [N_CH-1:0]       access_denied;
  logic [N_CH-1:0]       locked;
  logic [N_CH*CNT_W-1:0] fail_count;
  logic [N_CH-1:0]       irq_status;
  logic                  irq;

  access_monitor_mc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .attempt_valid  (attempt_valid),
    .attempt_match  (attempt_match),
    .cfg_fail_max   (cfg_fail_max),
    .irq_clr        (irq_clr),
    .access_granted (access_granted),
    .access_denied  (access_denied),
    .locked         (locked),
    .fail_count     (fail_count),
    .irq_status     (irq_status),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0]       gr;
    logic [N_CH-1:0]       dn;
    logic [N_CH-1:0]       lk;
    logic [N_CH*CNT_W-1:0] fc;
    logic [N_CH-1:0]       irqs;
    logic                  irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_cnt  [N_CH];
  bit m_irq  [N_CH];
  int m_lock [N_CH];  // cycles of lockout still to run

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_cnt[c]  = 0;
      m_irq[c]  = 1'b0;
      m_lock[c] = 0;
    end
  endtask

  task automatic model_step(input logic [N_CH-1:0] v, input logic [N_CH-1:0] m,
                            input logic [N_CH-1:0] clr, input logic [CNT_W-1:0] cfg);
    exp_t e;
    int   thr;
    bit   was_locked;
    bit   set;
    e   = '0;
    thr = (cfg == 0) ? 1 : int'(cfg);
    for (int c = 0; c < N_CH; c++) begin
      set        = 1'b0;
      was_locked = m_lock[c] > 0;
      if (was_locked) m_lock[c]--;
      if (v[c]) begin
        if (was_locked) begin
          e.dn[c] = 1'b1;
        end else if (m[c]) begin
          e.gr[c]  = 1'b1;
          m_cnt[c] = 0;
        end else begin
          e.dn[c] = 1'b1;
          if (m_cnt[c] + 1 >= thr) set = 1'b1;
          m_cnt[c] = (m_cnt[c] == 15) ? 15 : m_cnt[c] + 1;
`ifdef ACCESS_MON_LOCKOUT_EN
          if (set) begin
            m_cnt[c]  = 0;
            m_lock[c] = LOCK_CYCLES;
          end
`endif
        end
      end
      if (clr[c]) m_irq[c] = 1'b0;
      if (set)    m_irq[c] = 1'b1;
      e.lk[c]               = m_lock[c] > 0;
      e.fc[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
      e.irqs[c]             = m_irq[c];
    end
    e.irq = |e.irqs;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then score the DUT after the edge.
  task automatic step(input string tag, input logic [N_CH-1:0] v, input logic [N_CH-1:0] m,
                      input logic [N_CH-1:0] clr);
    exp_t e;
    attempt_valid = v;
    attempt_match = m;
    irq_clr       = clr;
    model_step(v, m, clr, cfg_fail_max);
    @(posedge clk);
    #1;
    attempt_valid = '0;
    attempt_match = '0;
    irq_clr       = '0;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue, want one entry", tag);
    end else begin
      e = sb_q.pop_front();
      n_tests += 5;
      if (access_granted !== e.gr) begin
        n_fail++;
        $display("FAIL %s granted: got %b want %b", tag, access_granted, e.gr);
      end
      if (access_denied !== e.dn) begin
        n_fail++;
        $display("FAIL %s denied: got %b want %b", tag, access_denied, e.dn);
      end
      if (locked !== e.lk) begin
        n_fail++;
        $display("FAIL %s locked: got %b want %b", tag, locked, e.lk);
      end
      if (fail_count !== e.fc) begin
        n_fail++;
        $display("FAIL %s fail_count: got %h want %h", tag, fail_count, e.fc);
      end
      if (irq_status !== e.irqs) begin
        n_fail++;
        $display("FAIL %s irq_status: got %b want %b", tag, irq_status, e.irqs);
      end
      if (irq !== e.irq) begin
        n_fail++;
        $display("FAIL %s irq: got %b want %b", tag, irq, e.irq);
      end
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, '0, '0, '0);
  endtask

  task automatic test_reset();
    cfg_fail_max = 4'd3;
    step("rst_pre", 4'b0010, 4'b0000, '0);
    step("rst_pre", 4'b0010, 4'b0000, '0);
    step("rst_pre", 4'b0001, 4'b0001, '0);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({access_granted, access_denied, locked, fail_count, irq_status, irq} !== '0) begin
      n_fail++;
      $display("FAIL rst_async outputs: got gr=%b dn=%b lk=%b fc=%h irqs=%b irq=%b want all 0",
               access_granted, access_denied, locked, fail_count, irq_status, irq);
    end
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    attempt_valid = 4'b0001;
    attempt_match = 4'b0001;
    #1;
    n_tests++;
    if (access_granted !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_early_grant: got %b want 0000", access_granted);
    end
    step("rst_first_grant", 4'b0001, 4'b0001, '0);
    idle("rst_idle", 1);
  endtask

  task automatic test_fail_then_match();
    cfg_fail_max = 4'd3;
    step("fm_fail1", 4'b0001, 4'b0000, '0);
    step("fm_fail2", 4'b0001, 4'b0000, '0);
    step("fm_match", 4'b0001, 4'b0001, '0);
    idle("fm_idle", 1);
  endtask

  task automatic test_trip();
    cfg_fail_max = 4'd3;
    for (int i = 0; i < 3; i++) step("trip_fail", 4'b0010, 4'b0000, '0);
    for (int i = 0; i < 18; i++) begin
      if (i == 4) step("trip_match_in_lock", 4'b0010, 4'b0010, '0);
      else        step("trip_wait", '0, '0, '0);
    end
  endtask

  task automatic test_irq_clr();
    step("clr_lone", '0, '0, 4'b0010);
    step("clr_rearm", 4'b0010, 4'b0010, '0);
    step("clr_fail1", 4'b0010, 4'b0000, '0);
    step("clr_fail2", 4'b0010, 4'b0000, '0);
    step("clr_set_wins", 4'b0010, 4'b0000, 4'b0010);
    step("clr_lone2", '0, '0, 4'b0010);
    idle("clr_wait", 17);
  endtask

  task automatic test_threshold();
    cfg_fail_max = 4'd0;
    step("thr0_trip", 4'b0100, 4'b0000, '0);
    for (int i = 0; i < 20; i++) step("thr0_sat", 4'b0100, 4'b0000, '0);
    idle("thr0_wait", 17);
    cfg_fail_max = 4'd3;
    step("thr_low_match", 4'b1000, 4'b1000, '0);
    step("thr_low_fail1", 4'b1000, 4'b0000, '0);
    step("thr_low_fail2", 4'b1000, 4'b0000, '0);
    cfg_fail_max = 4'd1;
    step("thr_low_trip", 4'b1000, 4'b0000, '0);
    idle("thr_low_wait", 17);
  endtask

  task automatic test_all_channels();
    cfg_fail_max = 4'd3;
    step("all_clr", '0, '0, 4'b1111);
    step("all_zero", 4'b1111, 4'b1111, '0);
    step("all_mix1", 4'b1111, 4'b1001, '0);
    step("all_mix2", 4'b1111, 4'b1001, '0);
    step("all_mix3", 4'b1111, 4'b1001, '0);
    step("all_b2b", 4'b1111, 4'b0110, '0);
    idle("all_idle", 2);
  endtask

  initial begin
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_fail_then_match();
    test_trip();
    test_irq_clr();
    test_threshold();
    test_all_channels();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
